// File: rtl/chunked_add_sub.sv
// -----------------------------------------------------------------------------
// chunked_add_sub
//
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair is
// pushed through one CHUNK-bit ripple-carry slice, least significant chunk
// first, one chunk per clock. The carry is registered between chunks, so the
// combinational carry chain never exceeds CHUNK bits whatever WIDTH is.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of CHUNK
//   CHUNK  bits added per clock (slice width), WIDTH/CHUNK >= 1
//
// Ports:
//   clock     rising-edge clock
//   resetn    asynchronous active-low reset
//   start     request, sampled only in IDLE or DONE
//   a, b      operands (WIDTH bits)
//   cin       carry-in for add, borrow-in for subtract
//   sub       0: a+b+cin, 1: a-b-cin
//   acc       (only with CHUNKED_ADD_SUB_ACCUMULATE_EN) take operand A from s
//   busy      high while the slice is stepping through chunks
//   done      one-cycle pulse when s/cout/overflow are valid
//   s         result, held until the next accepted start
//   cout      final carry out (subtract: 1 = no borrow)
//   overflow  signed overflow of the completed operation
//
// Optional build macro: CHUNKED_ADD_SUB_ACCUMULATE_EN adds the acc port.
// -----------------------------------------------------------------------------
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CHUNKED_ADD_SUB_ACCUMULATE_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the index at least one bit wide so NCHUNK=1 still elaborates.
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_opA;
  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK:0]   w_sum;
  logic             w_carryMsb;
  logic             w_lastChunk;

  // Operand A source: the running result when accumulating, else the a port.
`ifdef CHUNKED_ADD_SUB_ACCUMULATE_EN
  assign w_opA = acc ? r_s : a;
`else
  assign w_opA = a;
`endif

  // Select the current chunk of each latched operand and add it with the
  // registered carry through a single CHUNK-bit slice.
  assign w_shift    = 32'(r_idx) * 32'(CHUNK);
  assign w_aChunk   = CHUNK'(r_a >> w_shift);
  assign w_bChunk   = CHUNK'(r_b >> w_shift);
  assign w_sum      = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_lastChunk = (r_idx == IDXW'(NCHUNK - 1));

  // The carry into the top bit of a chunk is recovered from that bit's sum,
  // since sum = a ^ b ^ carry_in. On the last chunk this is the carry into
  // bit WIDTH-1, which together with the final carry gives signed overflow.
  assign w_carryMsb = w_aChunk[CHUNK-1] ^ w_bChunk[CHUNK-1] ^ w_sum[CHUNK-1];

  // Control FSM and datapath registers. Subtraction is a + ~b + ~borrow, so
  // b is inverted at accept and the initial carry is cin XOR sub. IDLE and
  // DONE share the accept path so a start in the done cycle runs back-to-back.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= w_opA;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
              r_s[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            end
          end
          r_carry <= w_sum[CHUNK];
          if (w_lastChunk) begin
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= w_carryMsb ^ w_sum[CHUNK];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign s        = r_s;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_chunked_add_sub.sv
// -----------------------------------------------------------------------------
// tb_chunked_add_sub
//
// Self-checking bench for chunked_add_sub with WIDTH=16, CHUNK=4. Expected
// results come from an integer arithmetic model, are queued when a start is
// driven and popped when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_chunked_add_sub;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clock;
  logic             resetn;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;

  int checks;
  int failures;
  result_t sbQueue[$];
  logic [WIDTH-1:0] modelS;

  chunked_add_sub #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .sub     (sub),
`ifdef CHUNKED_ADD_SUB_ACCUMULATE_EN
    .acc     (acc),
`endif
    .busy    (busy),
    .done    (done),
    .s       (s),
    .cout    (cout),
    .overflow(overflow)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers: unsigned sum/difference for s and
  // cout, signed sum/difference range check for overflow.
  function automatic result_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                    input logic ci, input logic su);
    result_t r;
    int ua, ub, sa, sb, c, full, sres;
    ua = int'(aa);
    ub = int'(bb);
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    c  = int'(ci);
    if (!su) begin
      full   = ua + ub + c;
      r.cout = (full > 65535);
      sres   = sa + sb + c;
    end else begin
      full   = ua - ub - c;
      r.cout = (full >= 0);
      sres   = sa - sb - c;
    end
    r.s   = full[WIDTH-1:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  // Drive one request on a falling edge, queue its expected result, and drop
  // start after the accepting rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                               input logic ci, input logic su, input logic ac);
    result_t exp;
    a     = aa;
    b     = bb;
    cin   = ci;
    sub   = su;
    acc   = ac;
    start = 1'b1;
    exp   = model(ac ? modelS : aa, bb, ci, su);
    modelS = exp.s;
    sbQueue.push_back(exp);
    @(negedge clock);
    start = 1'b0;
    acc   = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("done_after_start", 32'(done), 32'd0);
  endtask

  // Bounded wait for done, sampled on falling edges.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cycles++;
      if (done) break;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Pop the oldest expected result and compare against the outputs.
  task automatic compareResult(input string tag);
    result_t exp;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sbQueue.pop_front();
      checkOutput({tag, "_s"}, 32'(s), 32'(exp.s));
      checkOutput({tag, "_cout"}, 32'(cout), 32'(exp.cout));
      checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp.ovf));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  // One complete operation: drive, wait, check latency and result.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic ci, input logic su, input logic ac);
    int cyc;
    applyStimulus(aa, bb, ci, su, ac);
    waitDone(tag, cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(NCHUNK));
    compareResult(tag);
  endtask

  initial begin
    int cyc;
    int doneSeen;
    checks   = 0;
    failures = 0;
    modelS   = '0;
    clock    = 1'b0;
    resetn   = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    acc      = 1'b0;

    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_s", 32'(s), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    runOp("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    runOp("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    runOp("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    runOp("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    runOp("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    runOp("sub_borrow",16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0);
    runOp("add_cin",   16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    checkOutput("add_cin_ready", 32'(done), 32'd1);
    @(negedge clock);

    // Start held high through RUN: operand changes after accept are ignored.
    a     = 16'h00FF;
    b     = 16'h0001;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    sbQueue.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    modelS = 16'h0100;
    @(negedge clock);
    a   = 16'hAAAA;
    b   = 16'h5555;
    sub = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    waitDone("hold_start", cyc);
    checkOutput("hold_start_latency", 32'(cyc), 32'd2);
    compareResult("hold_start");
    doneSeen = 0;
    repeat (4) begin
      @(negedge clock);
      if (done) doneSeen++;
    end
    checkOutput("hold_start_no_redo", 32'(doneSeen), 32'd0);
    checkOutput("hold_start_idle", 32'(busy), 32'd0);

    // Back-to-back: second request issued in the first done cycle.
    applyStimulus(16'h1000, 16'h0234, 1'b0, 1'b0, 1'b0);
    waitDone("b2b_first", cyc);
    compareResult("b2b_first");
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    waitDone("b2b_second", cyc);
    checkOutput("b2b_gap", 32'(cyc + 1), 32'(NCHUNK + 1));
    compareResult("b2b_second");
    @(negedge clock);

    // Reset mid-RUN: earlier op leaves cout=1/overflow=1, then abort.
    runOp("pre_reset", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_s", 32'(s), 32'd0);
    checkOutput("async_rst_cout", 32'(cout), 32'd0);
    checkOutput("async_rst_ovf", 32'(overflow), 32'd0);
    sbQueue.delete();
    modelS = '0;
    @(negedge clock);
    resetn = 1'b1;
    doneSeen = 0;
    repeat (8) begin
      @(negedge clock);
      if (done || busy) doneSeen++;
    end
    checkOutput("rst_no_done", 32'(doneSeen), 32'd0);
    runOp("post_reset", 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

`ifdef CHUNKED_ADD_SUB_ACCUMULATE_EN
    runOp("acc_seed", 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    runOp("acc_add", 16'hDEAD, 16'h0010, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    runOp("acc_sub", 16'hBEEF, 16'h0110, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
